// File: rtl/bcd_updown_sseg_display.sv
// bcd_updown_sseg_display: prescaled BCD up/down counter with load, wrap/saturate, tc pulse and blanked multiplexed display
module bcd_updown_sseg_display #(
  parameter int N = 3,
  parameter int DIGITS = 4,
  parameter int REFRESH_BITS = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  direction,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  sat_mode,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [7:0]            an,
  output logic [7:0]            sseg
);
  logic [N-1:0] psc;
  logic [REFRESH_BITS-1:0] div;
  logic [2:0] idx;
  logic tick, c, b, wrap, seen;
  logic [4*DIGITS-1:0] inc, dec, ld;
  logic [31:0] pad;
  logic [7:0] blank;
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction
  assign tick = en & (&psc);
  assign pad = 32'(count);
  assign wrap = direction ? b : c;
  always_comb begin
    c = 1'b1;
    b = 1'b1;
    inc = '0;
    dec = '0;
    ld = '0;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i +: 4] = (c && count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + {3'd0, c};
      dec[4*i +: 4] = (b && count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - {3'd0, b};
      ld[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      c = c & (count[4*i +: 4] == 4'd9);
      b = b & (count[4*i +: 4] == 4'd0);
    end
  end
  // a digit is blank when it and every digit above it are zero
  always_comb begin
    seen = 1'b0;
    blank = '0;
    for (int i = 7; i >= 0; i--) begin
      seen = seen | (pad[4*i +: 4] != 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && !seen;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
      count <= '0;
      tc <= 1'b0;
    end else if (load) begin
      psc <= '0;
      count <= ld;
      tc <= 1'b0;
    end else begin
      psc <= en ? psc + 1'b1 : psc;
      tc <= tick & wrap & ~sat_mode;
      if (tick && !(wrap && sat_mode)) count <= direction ? dec : inc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      an <= 8'hFE;
      sseg <= 8'hC0;
    end else begin
      div <= div + 1'b1;
      if (&div) idx <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      an <= ~(8'd1 << idx);
      sseg <= blank[idx] ? 8'hFF : seg7(pad[{idx, 2'b00} +: 4]);
    end
  end
endmodule

// File: doc/bcd_updown_sseg_display.md
Name: bcd_updown_sseg_display

Overview:
Parametrised successor of the team's up/down counter-to-seven-segment wrapper. It holds a DIGITS-wide BCD up/down counter advanced by an internal 2^N prescaler. It adds synchronous load, wrap/saturate mode, a terminal-count pulse and leading-zero blanking, and time-multiplexes the digits onto the board's 8-anode, active-low seven-segment display.

Parameters:
N, 3, prescaler width; one count tick every 2^N enabled clocks (sim uses 3, board uses 26)
DIGITS, 4, number of BCD digits counted and displayed, legal 1..8
REFRESH_BITS, 2, digit-scan divider; the displayed digit advances every 2^REFRESH_BITS clocks (board uses 17)
BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  count enable; gates the prescaler and count
direction  in  1  0 = count up, 1 = count down
load  in  1  synchronous load strobe
load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0]
sat_mode  in  1  0 = wrap at limits, 1 = saturate
count  out  4*DIGITS  current BCD value, registered
tc  out  1  one-cycle pulse on wrap-around
an  out  8  anode selects, active-low one-hot
sseg  out  8  {dp, g,f,e,d,c,b,a}, active-low

Behaviour:
- All state is on the rising edge of clk. The only reset is rst: synchronous, active-high, and it takes priority over everything.
- Reset values: prescaler 0, count 0, tc 0, scan index 0, scan divider 0, an = 8'hFE, sseg = 8'hC0 (digit 0 showing "0", dp off).
- Prescaler:
  - N-bit; increments only when en=1 and holds when en=0.
  - tick = en & (prescaler == all ones); the prescaler wraps to 0 on that same edge.
- Priority order after rst: load, then tick, then hold.
- load=1:
  - count <= load_val, with any digit >9 clamped to 9.
  - Prescaler <= 0; tc stays 0.
  - load with en=0 still loads.
- tick with direction=0 (up):
  - BCD increment: digit 9 -> 0 with carry into the next digit.
  - At the maximum (all 9s): sat_mode=0 -> count <= 0 and tc=1 for exactly one cycle; sat_mode=1 -> count holds and tc=0.
- tick with direction=1 (down):
  - BCD decrement: digit 0 -> 9 with borrow from the next digit.
  - At 0: sat_mode=0 -> count <= all 9s and tc=1; sat_mode=1 -> count holds.
- direction and sat_mode are sampled only on tick edges; changing them between ticks has no other effect.
- count updates on the edge where tick=1, so count is visible the cycle after that edge.
- tc is registered and is high only in the cycle following a wrapping tick.
- Display scan:
  - The scan divider runs freely, independent of en.
  - When the divider reaches all ones, the scan index advances 0..DIGITS-1 and then wraps to 0.
  - an/sseg are registered from the scan index and count, so the display lags the internal state by one clock.
  - an[i]=0 only for i = scan index. an bits at or above DIGITS are always 1.
  - sseg[7] (dp) is always 1.
  - Decode (hex, active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
- Blanking (BLANK_LZ=1):
  - Any digit above the most-significant nonzero digit shows sseg=8'hFF.
  - Its anode is still driven.
  - Digit 0 is never blanked.
- Reset mid-count or mid-scan returns every output to the reset values on the next edge.
- Simultaneous load and tick: the load wins and the tick is lost.

Test Plan:
1. rst=1 for 2 clocks, then rst=0, en=1, direction=0, N=3 -> count 0000 -> 0001 after 8 clocks, 0002 after 16; an/sseg reset to FE/C0.
2. load 9998, sat_mode=0, count up -> 9999, then 0000 with tc high exactly one cycle; sat_mode=1 repeat -> holds at 9999, tc stays 0.
3. load 0001, direction=1 -> 0000, then 9999 with tc pulse; sat_mode=1 -> holds at 0000.
4. en=0 for 30 clocks mid-count -> count and prescaler frozen; the scan keeps cycling an FE, FD, FB, F7 every 4 clocks (REFRESH_BITS=2).
5. count 0042, BLANK_LZ=1 -> digits 3 and 2 show FF, digit 1 shows 99, digit 0 shows A4; load_val 00A5 loads as 0095.
6. load and tick asserted on the same edge -> count equals load_val; rst asserted mid-scan -> an=FE, sseg=C0, count=0 next cycle.
